// File: rtl/whack_game_ctrl.sv
// whack_game_ctrl: sequencing controller for the whack-a-mole game.
// Runs IDLE -> LOAD -> ARM -> PLAY -> OVER. It places one mole at a time on
// one of four holes, using an 8-bit LFSR to pick the hole. It counts hits,
// saturating at 255, and retires a mole on a hit or after MOLE_TICKS cycles.
//
// Ports:
//   CLOCK_50     in   clock, rising edge
//   reset_n      in   async active-low reset
//   start_btn    in   start request pulse (honoured in IDLE/OVER only)
//   whack[3:0]   in   per-hole hit pulses
//   time_left[7:0] in remaining seconds from the game timer
//   load_time    out  one-cycle load strobe to the game timer
//   parload      out  coincident with load_time
//   start_timer  out  timer count enable, high in PLAY
//   mole[3:0]    out  one-hot active hole, 0 when no mole is up
//   score[7:0]   out  hits this game, saturating
//   game_over    out  high in OVER
module whack_game_ctrl #(
   parameter int unsigned MOLE_TICKS = 50_000_000,
   parameter logic [7:0]  LFSR_SEED  = 8'hA5
) (
   input  logic       CLOCK_50,
   input  logic       reset_n,
   input  logic       start_btn,
   input  logic [3:0] whack,
   input  logic [7:0] time_left,
   output logic       load_time,
   output logic       parload,
   output logic       start_timer,
   output logic [3:0] mole,
   output logic [7:0] score,
   output logic       game_over
);

   typedef enum logic [2:0] {S_IDLE, S_LOAD, S_ARM, S_PLAY, S_OVER} state_t;

   localparam logic [25:0] RELOAD = 26'(MOLE_TICKS - 1);

   state_t      state_q, state_d;
   logic [7:0]  lfsr_q, lfsr_d;
   logic [25:0] mtmr_q, mtmr_d;
   logic [3:0]  mole_q, mole_d;
   logic [7:0]  score_q, score_d;
   logic        load_q, load_d;
   logic        start_q, start_d;
   logic        over_q, over_d;

   logic [1:0]  cur_idx, cand, sel;
   logic [3:0]  spawn;

   // Fibonacci LFSR, x^8+x^6+x^5+x^4+1; free-running in every state.
   assign lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};

   // Candidate hole from the LFSR; bump by one if it would repeat the
   // current mole. With no mole up (first spawn) the candidate is used as-is.
   always_comb begin
      cur_idx = 2'd0;
      case (mole_q)
         4'b0010: cur_idx = 2'd1;
         4'b0100: cur_idx = 2'd2;
         4'b1000: cur_idx = 2'd3;
         default: cur_idx = 2'd0;
      endcase
      cand = lfsr_q[1:0];
      sel  = ((mole_q != 4'b0000) && (cand == cur_idx)) ? cand + 2'd1 : cand;
      spawn = 4'b0001 << sel;
   end

   always_comb begin
      state_d = state_q;
      mole_d  = mole_q;
      score_d = score_q;
      mtmr_d  = mtmr_q;
      case (state_q)
         S_IDLE: begin
            if (start_btn) begin
               state_d = S_LOAD;
               score_d = 8'd0;
            end
         end
         S_LOAD: state_d = S_ARM;
         S_ARM: begin
            // Hold until the timer reports its freshly loaded length.
            if (time_left != 8'd0) begin
               state_d = S_PLAY;
               mole_d  = spawn;
               mtmr_d  = RELOAD;
            end
         end
         S_PLAY: begin
            if (time_left == 8'd0) begin
               // End of game wins over a hit in the same cycle.
               state_d = S_OVER;
               mole_d  = 4'b0000;
            end else if ((whack & mole_q) != 4'b0000) begin
               score_d = (score_q == 8'hFF) ? score_q : score_q + 8'd1;
               mole_d  = spawn;
               mtmr_d  = RELOAD;
            end else if (mtmr_q == 26'd0) begin
               mole_d  = spawn;
               mtmr_d  = RELOAD;
            end else begin
               mtmr_d  = mtmr_q - 26'd1;
            end
         end
         S_OVER: begin
            mole_d = 4'b0000;
            if (start_btn) begin
               state_d = S_LOAD;
               score_d = 8'd0;
            end
         end
         default: begin
            state_d = S_IDLE;
            mole_d  = 4'b0000;
         end
      endcase
      // Strobes are registered so they line up with the state they belong to.
      load_d  = (state_d == S_LOAD);
      start_d = (state_d == S_PLAY);
      over_d  = (state_d == S_OVER);
   end

   always_ff @(posedge CLOCK_50 or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= S_IDLE;
         lfsr_q  <= LFSR_SEED;
         mtmr_q  <= 26'd0;
         mole_q  <= 4'b0000;
         score_q <= 8'd0;
         load_q  <= 1'b0;
         start_q <= 1'b0;
         over_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         lfsr_q  <= lfsr_d;
         mtmr_q  <= mtmr_d;
         mole_q  <= mole_d;
         score_q <= score_d;
         load_q  <= load_d;
         start_q <= start_d;
         over_q  <= over_d;
      end
   end

   assign load_time   = load_q;
   assign parload     = load_q;
   assign start_timer = start_q;
   assign mole        = mole_q;
   assign score       = score_q;
   assign game_over   = over_q;

endmodule

// File: tb/tb_whack_game_ctrl.sv
// Directed bench for whack_game_ctrl with MOLE_TICKS=8.
// It keeps its own LFSR reference so it can predict each spawned hole.
module tb_whack_game_ctrl;

   logic       clk = 1'b0;
   logic       rst_n = 1'b1;
   logic       start_btn = 1'b0;
   logic [3:0] whack = 4'b0000;
   logic [7:0] time_left = 8'd0;
   logic       load_time, parload, start_timer, game_over;
   logic [3:0] mole;
   logic [7:0] score;

   int total = 0;
   int bad = 0;

   whack_game_ctrl #(.MOLE_TICKS(8), .LFSR_SEED(8'hA5)) dut (
      .CLOCK_50(clk), .reset_n(rst_n), .start_btn(start_btn), .whack(whack),
      .time_left(time_left), .load_time(load_time), .parload(parload),
      .start_timer(start_timer), .mole(mole), .score(score), .game_over(game_over)
   );

   always #5 clk = ~clk;

   // Reference LFSR: m_prev holds the value the DUT sampled on the last edge.
   logic [7:0] m_lfsr, m_prev;
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_lfsr <= 8'hA5;
         m_prev <= 8'hA5;
      end else begin
         m_prev <= m_lfsr;
         m_lfsr <= {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
      end
   end

   function automatic logic [3:0] exp_spawn(input logic [7:0] l, input logic [3:0] cur);
      logic [1:0] h;
      h = l[1:0];
      if (cur == (4'b0001 << h)) h = h + 2'd1;
      return 4'b0001 << h;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      #2 rst_n = 1'b0;
      #1;
      total++;
      if ({load_time, parload, start_timer, game_over, mole, score} !== 16'd0) begin
         bad++;
         $display("FAIL reset_outputs got=%h want=0",
                  {load_time, parload, start_timer, game_over, mole, score});
      end
      step();
      #3 rst_n = 1'b1;
      step();
      step();
      total++;
      if ({load_time, start_timer, game_over, mole} !== 7'd0) begin
         bad++;
         $display("FAIL idle_outputs got=%b want=0", {load_time, start_timer, game_over, mole});
      end
   endtask

   task automatic test_start();
      logic [3:0] old;
      start_btn = 1'b1;
      step();
      start_btn = 1'b0;
      total++;
      if ({load_time, parload, start_timer} !== 3'b110) begin
         bad++;
         $display("FAIL load_pulse got=%b want=110", {load_time, parload, start_timer});
      end
      step();
      total++;
      if ({load_time, parload, score} !== 10'd0) begin
         bad++;
         $display("FAIL load_one_cycle got=%b want=0", {load_time, parload, score});
      end
      step();
      step();
      total++;
      if ({start_timer, mole} !== 5'd0) begin
         bad++;
         $display("FAIL arm_wait got=%b want=0", {start_timer, mole});
      end
      time_left = 8'd60;
      old = mole;
      step();
      total++;
      if (start_timer !== 1'b1 || mole !== exp_spawn(m_prev, old)) begin
         bad++;
         $display("FAIL play_entry start=%b mole=%b want start=1 mole=%b",
                  start_timer, mole, exp_spawn(m_prev, old));
      end
   endtask

   task automatic test_hit();
      logic [3:0] old;
      old = mole;
      whack = mole;
      step();
      whack = 4'b0000;
      total++;
      if (score !== 8'd1 || mole !== exp_spawn(m_prev, old) || mole === old) begin
         bad++;
         $display("FAIL hit got score=%0d mole=%b want score=1 mole=%b",
                  score, mole, exp_spawn(m_prev, old));
      end
      old = mole;
      whack = ~mole;
      step();
      whack = 4'b0000;
      total++;
      if (score !== 8'd1 || mole !== old) begin
         bad++;
         $display("FAIL wrong_hole got score=%0d mole=%b want score=1 mole=%b", score, mole, old);
      end
   endtask

   task automatic test_timeout();
      logic [3:0] old;
      int cnt;
      // Sync up to the first mole change, then time whole mole lifetimes.
      for (int k = 0; k < 4; k++) begin
         old = mole;
         cnt = 0;
         do begin
            step();
            cnt++;
         end while (mole === old && cnt < 20);
         if (k > 0) begin
            total++;
            if (cnt != 8) begin
               bad++;
               $display("FAIL timeout_len got=%0d want=8", cnt);
            end
         end
         total++;
         if (mole !== exp_spawn(m_prev, old) || !$onehot(mole) || mole === old || score !== 8'd1) begin
            bad++;
            $display("FAIL timeout_spawn got mole=%b score=%0d want mole=%b score=1",
                     mole, score, exp_spawn(m_prev, old));
         end
      end
   endtask

   task automatic test_game_end();
      time_left = 8'd0;
      whack = mole;
      step();
      time_left = 8'd60;
      whack = 4'b0000;
      total++;
      if ({game_over, start_timer, mole} !== 6'b100000 || score !== 8'd1) begin
         bad++;
         $display("FAIL game_end got go=%b st=%b mole=%b score=%0d want go=1 st=0 mole=0 score=1",
                  game_over, start_timer, mole, score);
      end
      step();
      total++;
      if (game_over !== 1'b1 || mole !== 4'b0000) begin
         bad++;
         $display("FAIL over_hold got go=%b mole=%b want go=1 mole=0", game_over, mole);
      end
      start_btn = 1'b1;
      step();
      start_btn = 1'b0;
      total++;
      if (load_time !== 1'b1 || game_over !== 1'b0) begin
         bad++;
         $display("FAIL restart got load=%b go=%b want load=1 go=0", load_time, game_over);
      end
      step();
      total++;
      if (score !== 8'd0) begin
         bad++;
         $display("FAIL restart_score got=%0d want=0", score);
      end
      step();
      total++;
      if (start_timer !== 1'b1 || !$onehot(mole)) begin
         bad++;
         $display("FAIL replay got st=%b mole=%b want st=1 onehot", start_timer, mole);
      end
   endtask

   task automatic test_back_to_back_saturation();
      int errs;
      int want;
      errs = 0;
      for (int i = 0; i < 256; i++) begin
         whack = mole;
         step();
         want = (i + 1 > 255) ? 255 : i + 1;
         if (score !== 8'(want)) errs++;
      end
      whack = 4'b0000;
      total++;
      if (errs != 0) begin
         bad++;
         $display("FAIL sat_track got errs=%0d want=0", errs);
      end
      total++;
      if (score !== 8'd255) begin
         bad++;
         $display("FAIL sat_final got=%0d want=255", score);
      end
      whack = mole;
      step();
      whack = 4'b0000;
      total++;
      if (score !== 8'd255 || !$onehot(mole)) begin
         bad++;
         $display("FAIL sat_hold got score=%0d mole=%b want 255 onehot", score, mole);
      end
   endtask

   task automatic test_async_reset();
      step();
      #2 rst_n = 1'b0;
      #1;
      total++;
      if ({load_time, parload, start_timer, game_over, mole, score} !== 16'd0) begin
         bad++;
         $display("FAIL async_reset got=%h want=0",
                  {load_time, parload, start_timer, game_over, mole, score});
      end
      step();
      #3 rst_n = 1'b1;
      step();
      step();
      total++;
      if ({start_timer, load_time, game_over, mole} !== 7'd0) begin
         bad++;
         $display("FAIL post_reset_idle got=%b want=0", {start_timer, load_time, game_over, mole});
      end
      start_btn = 1'b1;
      step();
      start_btn = 1'b0;
      total++;
      if (load_time !== 1'b1) begin
         bad++;
         $display("FAIL post_reset_start got=%b want=1", load_time);
      end
   endtask

   initial begin
      test_reset();
      test_start();
      test_hit();
      test_timeout();
      test_game_end();
      test_back_to_back_saturation();
      test_async_reset();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
